// File: rtl/ss_bus_sequencer.sv
// Savestate bus master: walks every bus address, reading slaves into a save stream
// or writing a load stream into slaves, holding each access for a fixed settle window.
package ss_addresses;
  localparam int SS_DATA_WIDTH = 64;
  localparam int SS_BUS_WIDTH  = 8;
endpackage

module ss_bus_sequencer
  import ss_addresses::*;
#(
  parameter int                      ADDRESS_END   = 64,
  parameter int                      SETTLE_CYCLES = 10,
  parameter logic [SS_BUS_WIDTH-1:0] IDLE_ADDR     = '1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_save,
  input  logic                     start_load,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [SS_DATA_WIDTH-1:0] save_data,
  output logic                     save_valid,
  input  logic                     save_ready,
  input  logic [SS_DATA_WIDTH-1:0] load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic [SS_BUS_WIDTH-1:0]  ss_bus_addr,
  output logic                     ss_bus_wren,
  output logic [SS_DATA_WIDTH-1:0] ss_bus_wdata,
  input  logic [SS_DATA_WIDTH-1:0] ss_bus_rdata,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_SETTLE = 3'd1,
    ST_SAVE_PUSH   = 3'd2,
    ST_LOAD_WAIT   = 3'd3,
    ST_LOAD_SETTLE = 3'd4
  } state_t;

  localparam logic [SS_BUS_WIDTH-1:0] LAST_ADDR = SS_BUS_WIDTH'(ADDRESS_END - 1);
  localparam logic [7:0]              CNT_INIT  = 8'(SETTLE_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [SS_BUS_WIDTH-1:0]  addr_q, addr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [SS_DATA_WIDTH-1:0] save_data_q, save_data_d;
  logic [SS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                     done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      save_data_q <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      save_data_q <= save_data_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
    end
  end

  // Streams use strict valid/ready: a word moves on a cycle where both are high;
  // valid (save side) and ready (load side) are decoded from state and never drop
  // until that transfer happens, except on abort or reset.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    save_data_d = save_data_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_save) begin
          state_d = ST_SAVE_SETTLE;
          addr_d  = '0;
          cnt_d   = CNT_INIT;
        end else if (start_load) begin
          state_d = ST_LOAD_WAIT;
          addr_d  = '0;
        end
      end
      ST_SAVE_SETTLE: begin
        if (cnt_q == 8'd0) begin
          save_data_d = ss_bus_rdata;
          state_d     = ST_SAVE_PUSH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SAVE_PUSH: begin
        if (save_ready) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ST_SAVE_SETTLE;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (load_valid) begin
          wdata_d = load_data;
          cnt_d   = CNT_INIT;
          state_d = ST_LOAD_SETTLE;
        end
      end
      ST_LOAD_SETTLE: begin
        if (cnt_q == 8'd0) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_LOAD_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  // Outputs depend on registers only; LOAD_WAIT parks on IDLE_ADDR so every write
  // presents a fresh address edge to the slaves.
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign save_valid   = (state_q == ST_SAVE_PUSH);
  assign load_ready   = (state_q == ST_LOAD_WAIT);
  assign ss_bus_wren  = (state_q == ST_LOAD_SETTLE);
  assign ss_bus_addr  = ((state_q == ST_SAVE_SETTLE) || (state_q == ST_SAVE_PUSH) ||
                         (state_q == ST_LOAD_SETTLE)) ? addr_q : IDLE_ADDR;
  assign save_data    = save_data_q;
  assign ss_bus_wdata = wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ss_bus_sequencer.sv
// Directed bench for ss_bus_sequencer with a 4-word memory slave on the bus.
module tb_ss_bus_sequencer;
  import ss_addresses::*;

  localparam int AEND   = 4;
  localparam int SETTLE = 10;
  localparam logic [SS_BUS_WIDTH-1:0] IDLE_A = '1;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start_save = 1'b0, start_load = 1'b0, abort = 1'b0;
  logic                     busy, done, save_valid, load_ready, ss_bus_wren;
  logic                     save_ready = 1'b1, load_valid = 1'b0;
  logic [SS_DATA_WIDTH-1:0] save_data, load_data = '0, ss_bus_wdata, ss_bus_rdata;
  logic [SS_BUS_WIDTH-1:0]  ss_bus_addr;
  logic [2:0]               dbg_state;

  ss_bus_sequencer #(.ADDRESS_END(AEND), .SETTLE_CYCLES(SETTLE), .IDLE_ADDR(IDLE_A)) dut (
    .clk(clk), .reset_n(reset_n), .start_save(start_save), .start_load(start_load),
    .abort(abort), .busy(busy), .done(done), .save_data(save_data),
    .save_valid(save_valid), .save_ready(save_ready), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .ss_bus_addr(ss_bus_addr),
    .ss_bus_wren(ss_bus_wren), .ss_bus_wdata(ss_bus_wdata),
    .ss_bus_rdata(ss_bus_rdata), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // memory-backed slave
  logic [SS_DATA_WIDTH-1:0] mem [AEND];
  initial for (int i = 0; i < AEND; i++) mem[i] = 64'hA0 + 64'(i);
  always @(posedge clk) if (ss_bus_wren && ss_bus_addr < AEND) mem[ss_bus_addr[1:0]] <= ss_bus_wdata;
  assign ss_bus_rdata = (ss_bus_addr < AEND) ? mem[ss_bus_addr[1:0]] : '0;

  // scoreboard
  logic [SS_DATA_WIDTH-1:0] exp_q[$];
  int hs_cyc[$];
  int total = 0, bad = 0;
  int done_cyc;
  logic [SS_DATA_WIDTH-1:0] ld_words [AEND];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_a0_words();
    for (int i = 0; i < AEND; i++) exp_q.push_back(64'hA0 + 64'(i));
  endtask

  // Full save: optional stall on one word, optional start_load held alongside.
  task automatic run_save(input int stall_word, input int stall_len, input bit with_load,
                          output int t0);
    int stalled = 0;
    bit saw_lr = 0, got_done = 0;
    hs_cyc.delete();
    save_ready = 1'b1;
    start_save = 1'b1;
    start_load = with_load;
    t0 = cyc;
    tick();
    start_save = 1'b0;
    chk("save_c1_addr", ss_bus_addr, 0);
    chk("save_c1_busy", busy, 1);
    for (int n = 0; n < 300; n++) begin
      if (load_ready) saw_lr = 1;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        chk("done_busy_low", busy, 0);
        break;
      end
      if (save_valid) begin
        if (int'(ss_bus_addr) == stall_word && stalled < stall_len) begin
          save_ready = 1'b0;
          stalled++;
          chk("stall_addr", ss_bus_addr, 64'(stall_word));
          if (exp_q.size() > 0) chk("stall_data", save_data, exp_q[0]);
        end else begin
          save_ready = 1'b1;
          hs_cyc.push_back(cyc);
          if (exp_q.size() > 0) chk("save_word", save_data, exp_q.pop_front());
          else chk("save_extra_word", 1, 0);
        end
      end else begin
        save_ready = 1'b1;
      end
      tick();
    end
    start_load = 1'b0;
    save_ready = 1'b1;
    chk("save_done_seen", got_done, 1);
    chk("save_no_load_ready", saw_lr, 0);
    chk("save_q_empty", exp_q.size(), 0);
    if (stall_len > 0) chk("stall_len", stalled, 64'(stall_len));
  endtask

  task automatic run_load(input int gap);
    int n, run, errs;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    for (int i = 0; i < AEND; i++) begin
      n = 0;
      while (!load_ready && n < 50) begin tick(); n++; end
      chk("ld_ready", load_ready, 1);
      chk("ld_park_addr", ss_bus_addr, IDLE_A);
      chk("ld_park_wren", ss_bus_wren, 0);
      repeat (gap) tick();
      load_valid = 1'b1;
      load_data  = ld_words[i];
      tick();
      load_valid = 1'b0;
      load_data  = {$urandom, $urandom};
      run = 0;
      errs = 0;
      while (ss_bus_wren && run < 50) begin
        if (ss_bus_addr != SS_BUS_WIDTH'(i) || ss_bus_wdata != ld_words[i]) errs++;
        run++;
        tick();
      end
      chk("ld_wren_len", run, SETTLE);
      chk("ld_write_addr_data", errs, 0);
      if (i < AEND - 1) begin
        chk("ld_next_ready", load_ready, 1);
        chk("ld_next_addr", ss_bus_addr, IDLE_A);
      end else begin
        chk("ld_done", done, 1);
        chk("ld_done_busy", busy, 0);
      end
    end
    tick();
    chk("ld_done_pulse", done, 0);
  endtask

  initial begin
    int t0;
    bit saw_done;
    // reset
    repeat (3) tick();
    chk("rst_addr_async", ss_bus_addr, IDLE_A);
    reset_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_save_valid", save_valid, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_wren", ss_bus_wren, 0);
    chk("rst_addr", ss_bus_addr, IDLE_A);
    chk("rst_save_data", save_data, 0);
    chk("rst_wdata", ss_bus_wdata, 0);
    chk("rst_state", dbg_state, 0);

    // plain save: latency and throughput
    push_a0_words();
    run_save(-1, 0, 0, t0);
    chk("first_word_cycle", hs_cyc[0] - t0, SETTLE + 1);
    for (int i = 1; i < AEND; i++) chk("word_spacing", hs_cyc[i] - hs_cyc[i-1], SETTLE + 1);
    chk("done_after_last", done_cyc - hs_cyc[AEND-1], 1);
    tick();
    chk("done_one_cycle", done, 0);

    // back-pressure on word 1
    push_a0_words();
    run_save(1, 20, 0, t0);
    tick();

    // both starts together, start_load held through the save
    push_a0_words();
    run_save(-1, 0, 1, t0);
    tick();
    chk("both_start_idle", busy, 0);

    // abort in SAVE_PUSH of word 2
    exp_q.push_back(64'hA0);
    exp_q.push_back(64'hA1);
    start_save = 1'b1;
    tick();
    start_save = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (save_valid && ss_bus_addr == 2) break;
      if (save_valid && exp_q.size() > 0) chk("abort_pre_word", save_data, exp_q.pop_front());
      tick();
    end
    chk("abort_at_word2", save_valid && ss_bus_addr == 2, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", save_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", ss_bus_addr, IDLE_A);
    saw_done = done;
    repeat (3) begin tick(); saw_done |= done; end
    chk("abort_no_done", saw_done, 0);
    chk("abort_q_empty", exp_q.size(), 0);
    push_a0_words();
    run_save(-1, 0, 0, t0);
    chk("restart_first_cycle", hs_cyc[0] - t0, SETTLE + 1);
    tick();

    // gapped load, then readback through the bus
    ld_words[0] = 64'h1111_2222_3333_4444;
    ld_words[1] = 64'hDEAD_BEEF_0000_0001;
    ld_words[2] = 64'h0000_0000_0000_0000;
    ld_words[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    run_load(5);
    for (int i = 0; i < AEND; i++) chk("mem_written", mem[i], ld_words[i]);
    for (int i = 0; i < AEND; i++) exp_q.push_back(ld_words[i]);
    run_save(-1, 0, 0, t0);
    tick();

    // asynchronous reset mid LOAD_SETTLE
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    load_valid = 1'b1;
    load_data  = 64'h5555;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_wren", ss_bus_wren, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wren", ss_bus_wren, 0);
    chk("arst_addr", ss_bus_addr, IDLE_A);
    chk("arst_busy", busy, 0);
    chk("arst_wdata", ss_bus_wdata, 0);
    chk("arst_save_data", save_data, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
